// File: rtl/mont_redc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mont_redc_pkg
// Description : Shared types and helpers for the Montgomery reduction engine:
//               FSM state encoding, digit-count derivation and width check.
// Revision    : 1.0 - initial release
// ============================================================================
package mont_redc_pkg;

    // Controller states: load in IDLE, K digit steps in ITER, final subtract in SUB
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_SUB  = 2'd2
    } state_t;

    // Number of DATA_WIDTH digits in an RSA_WIDTH modulus (iteration count K)
    function automatic int unsigned calc_num_words(input int unsigned rsa_w,
                                                   input int unsigned data_w);
        return rsa_w / data_w;
    endfunction

    // The modulus must split into a whole number of digits
    function automatic bit widths_ok(input int unsigned rsa_w,
                                     input int unsigned data_w);
        return (data_w != 0) && ((rsa_w % data_w) == 0);
    endfunction

    localparam int unsigned C_DEFAULT_RSA_WIDTH  = 4096;
    localparam int unsigned C_DEFAULT_DATA_WIDTH = 128;
    localparam bit          C_DEFAULT_WIDTHS_OK  =
        widths_ok(C_DEFAULT_RSA_WIDTH, C_DEFAULT_DATA_WIDTH);

endpackage : mont_redc_pkg
`default_nettype wire

// File: rtl/mont_redc_digit_step.sv
`default_nettype none
// ============================================================================
// Module      : mont_digit_step
// Description : One word-serial Montgomery step:
//               m = acc[D-1:0]*n' mod 2^D ; acc_next = (acc + m*n) >> D
// Revision    : 1.0 - initial release
// ============================================================================
module mont_digit_step #(
    parameter int unsigned RSA_WIDTH  = 4096,
    parameter int unsigned DATA_WIDTH = 128
) (
    input  logic [2*RSA_WIDTH:0]   acc,
    input  logic [RSA_WIDTH-1:0]   n,
    input  logic [DATA_WIDTH-1:0]  n_prime,
    output logic [2*RSA_WIDTH:0]   acc_next
);

    localparam int unsigned C_ACC_W  = 2 * RSA_WIDTH + 1;
    localparam int unsigned C_PROD_W = RSA_WIDTH + DATA_WIDTH;
    // One guard bit so the addition can never wrap before the shift
    localparam int unsigned C_SUM_W  = C_ACC_W + 1;

    logic [DATA_WIDTH-1:0] w_m;
    logic [C_PROD_W-1:0]   w_mn;

    // D-bit by D-bit product in a D-bit context keeps only the low digit
    assign w_m  = acc[DATA_WIDTH-1:0] * n_prime;
    assign w_mn = C_PROD_W'(n) * C_PROD_W'(w_m);

    // The low digit of the sum is zero by choice of m, so the shift is exact
    assign acc_next = C_ACC_W'((C_SUM_W'(acc) + C_SUM_W'(w_mn)) >> DATA_WIDTH);

endmodule : mont_digit_step
`default_nettype wire

// File: rtl/mont_redc.sv
`default_nettype none
// ============================================================================
// Module      : mont_redc
// Description : Word-serial Montgomery reduction, result = t * R^-1 mod n with
//               R = 2^RSA_WIDTH, one DATA_WIDTH digit reduced per clock.
// Revision    : 1.0 - initial release
// ============================================================================
module mont_redc
    import mont_redc_pkg::*;
#(
    parameter int unsigned RSA_WIDTH  = 4096,
    parameter int unsigned DATA_WIDTH = 128
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    go,
    input  logic [2*RSA_WIDTH-1:0]  t,
    input  logic [RSA_WIDTH-1:0]    n,
    input  logic [DATA_WIDTH-1:0]   n_prime,
    output logic [RSA_WIDTH-1:0]    result,
    output logic                    busy,
    output logic                    valid,
    output logic                    err
);

    localparam int unsigned NUM_WORDS  = calc_num_words(RSA_WIDTH, DATA_WIDTH);
    localparam bit          C_WIDTH_OK = widths_ok(RSA_WIDTH, DATA_WIDTH);
    localparam int unsigned C_ACC_W    = 2 * RSA_WIDTH + 1;
    localparam int unsigned C_IDX_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [C_IDX_W-1:0] C_IDX_LAST = C_IDX_W'(NUM_WORDS - 1);

    generate
        if (!C_WIDTH_OK) begin : g_width_check
            $error("mont_redc: RSA_WIDTH must be a non-zero multiple of DATA_WIDTH");
        end
    endgenerate

    state_t                 state_q,   state_d;
    logic [C_ACC_W-1:0]     acc_q,     acc_d;
    logic [C_IDX_W-1:0]     idx_q,     idx_d;
    logic [RSA_WIDTH-1:0]   n_q,       n_d;
    logic [DATA_WIDTH-1:0]  np_q,      np_d;
    logic [RSA_WIDTH-1:0]   result_q,  result_d;
    logic                   busy_q,    busy_d;
    logic                   valid_q,   valid_d;
    logic                   err_q,     err_d;

    logic [C_ACC_W-1:0]     w_acc_next;
    logic [C_ACC_W-1:0]     w_n_ext;
    logic                   w_acc_ge_n;
    logic [C_ACC_W-1:0]     w_acc_minus_n;

    mont_digit_step #(
        .RSA_WIDTH  (RSA_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_step (
        .acc      (acc_q),
        .n        (n_q),
        .n_prime  (np_q),
        .acc_next (w_acc_next)
    );

    // Final conditional subtraction brings acc from [0, 2n) into [0, n)
    assign w_n_ext       = C_ACC_W'(n_q);
    assign w_acc_ge_n    = (acc_q >= w_n_ext);
    assign w_acc_minus_n = acc_q - w_n_ext;

    // Next-state and datapath control; go is only honoured in IDLE
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        idx_d    = idx_q;
        n_d      = n_q;
        np_d     = np_q;
        result_d = result_q;
        busy_d   = busy_q;
        valid_d  = valid_q;
        err_d    = err_q;

        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    acc_d   = C_ACC_W'(t);
                    n_d     = n;
                    np_d    = n_prime;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    valid_d = 1'b0;
                    err_d   = 1'b0;
                    state_d = ST_ITER;
                end
            end
            ST_ITER: begin
                if (!n_q[0]) begin
                    // Even modulus has no inverse of R: abort with an error
                    result_d = '0;
                    err_d    = 1'b1;
                    valid_d  = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = ST_IDLE;
                end else begin
                    acc_d = w_acc_next;
                    idx_d = idx_q + C_IDX_W'(1);
                    if (idx_q == C_IDX_LAST) begin
                        state_d = ST_SUB;
                    end
                end
            end
            ST_SUB: begin
                result_d = w_acc_ge_n ? RSA_WIDTH'(w_acc_minus_n) : RSA_WIDTH'(acc_q);
                valid_d  = 1'b1;
                busy_d   = 1'b0;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            idx_q    <= '0;
            n_q      <= '0;
            np_q     <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            idx_q    <= idx_d;
            n_q      <= n_d;
            np_q     <= np_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    assign result = result_q;
    assign busy   = busy_q;
    assign valid  = valid_q;
    assign err    = err_q;

endmodule : mont_redc
`default_nettype wire
